// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the datapath it sequences.
//
// Signals
//   op, funct3, funct7b5 : instruction fields taken from the IR
//   Zero                 : ALU zero flag, same-cycle combinational
//   mem_ready            : memory access completes this cycle
//   PCWrite .. RegWrite  : datapath selects and enables
//   state_dbg            : current controller state encoding
//
// Handshake: mem_ready is a completion strobe. During FETCH, MEMREAD and MEMWRITE
// the controller holds its state and keeps the request asserted (address select,
// write strobe) until it samples mem_ready=1. Enables that commit the access
// (IRWrite/PCWrite in FETCH) are qualified by mem_ready in that same cycle.
//
// Modports: master = datapath side, slave = controller side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic [3:0] state_dbg;

    modport master (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, state_dbg
    );

    modport slave (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, state_dbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style controller for a shared multicycle RISC-V datapath (one ALU, one
// unified memory, IR/OldPC/Data/ALUOut registers). Decodes lw, sw, R-type,
// I-type ALU, beq/bne and jal; every memory access waits on mem_ready.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; forces the state to FETCH
//   bus    : controller side of multicycle_controller_if (instruction fields,
//            Zero, mem_ready in; all datapath selects/enables and state_dbg out)
//
// Parameter
//   SUPPORT_BNE : 1 = funct3 001 in the branch state means bne; 0 = all branches beq
module multicycle_controller #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_t state;
    state_t state_next;

    // op[5] separates R-type from I-type, so addi with IR[30]=1 stays an add.
    function automatic logic [2:0] alu_decode(input logic [6:0] o,
                                              input logic [2:0] f3,
                                              input logic       f7b5);
        case (f3)
            3'b000:  return (o[5] & f7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    assign bus.state_dbg = state;

    // Immediate format follows the opcode only, so it is valid in every state.
    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BR:   bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.RegWrite   = 1'b0;
        state_next     = FETCH;

        case (state)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                state_next    = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes OldPC + imm as the branch target.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_JAL:       state_next = JAL;
                    OP_BR:        state_next = BRANCH;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_next  = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_next = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                state_next   = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = alu_decode(bus.op, bus.funct3, bus.funct7b5);
                state_next     = ALUWB;
            end
            EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_decode(bus.op, bus.funct3, bus.funct7b5);
                state_next     = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
            end
            JAL: begin
                // ALUOut gets OldPC + 4 for rd while PC loads the target from ALUOut.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_next  = ALUWB;
            end
            BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = 3'b001;
                if (SUPPORT_BNE && bus.funct3 == 3'b001) bus.PCWrite = ~bus.Zero;
                else                                     bus.PCWrite = bus.Zero;
            end
            default: state_next = FETCH;
        endcase
    end

endmodule
